// File: rtl/program_loader.sv
// Boot-time loader: packs a little-endian byte stream into 32-bit words and writes them into program memory.
// Optional trailing XOR checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int          MEMORY_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_reset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] word_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(MEMORY_DEPTH);

  state_t      state_q;
  logic [15:0] len_q;
  logic [1:0]  idx_q;
  logic [31:0] word_q;
  logic [15:0] count_q;
  logic        ready_q, we_q, cpu_rst_q, busy_q, done_q, error_q;
  logic [31:0] addr_q, wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  chk_q;
`endif

  logic        xfer;
  logic [15:0] len_d;
  logic [15:0] count_d;

  always_comb begin
    xfer    = byte_valid_i && ready_q;
    len_d   = {byte_i, len_q[7:0]};
    count_d = count_q + 16'd1;
  end

  // Outputs are registered alongside the state, so each transition sets the
  // output values the destination state must present.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      count_q   <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      addr_q    <= BASE_ADDR;
      wdata_q   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state_q   <= S_LEN0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cpu_rst_q <= 1'b0;
            count_q   <= '0;
            idx_q     <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_q     <= '0;
`endif
          end
        end
        S_LEN0: begin
          if (xfer) begin
            len_q[7:0] <= byte_i;
            state_q    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (xfer) begin
            len_q <= len_d;
            if (len_d == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_q   <= S_CHK;
`else
              state_q   <= S_DONE;
              ready_q   <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b1;
`endif
            end else if ({1'b0, len_d} > DEPTH_W) begin
              state_q <= S_ERROR;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            word_q[{idx_q, 3'b000} +: 8] <= byte_i;
            idx_q <= idx_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_q <= chk_q ^ byte_i;
`endif
            if (idx_q == 2'd3) begin
              state_q <= S_WRITE;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
              addr_q  <= BASE_ADDR + {14'd0, count_q, 2'b00};
              wdata_q <= {byte_i, word_q[23:0]};
            end
          end
        end
        S_WRITE: begin
          count_q <= count_d;
          if (count_d == len_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_q   <= S_CHK;
            ready_q   <= 1'b1;
`else
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            cpu_rst_q <= 1'b1;
`endif
          end else begin
            state_q <= S_DATA;
            ready_q <= 1'b1;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            if (byte_i == chk_q) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready_o = ready_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign cpu_reset_o  = cpu_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign word_count_o = count_q;

endmodule
